debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Per-bit debouncer for synchronized mechanical inputs (buttons, switches) in the io_circuits group.
- Sits directly downstream of the two-stage synchronizer. Its input must already be in the clk domain; it never sees raw pad signals.
- Output goes high only after the input has been held high across PULSE_CNT_MAX consecutive sample ticks.
- Output drops one cycle after any low sample.

Parameters:
- WIDTH, 1, number of independent input bits.
- SAMPLE_CNT_MAX, 62500, clk cycles per sample tick. Must be >= 2.
- PULSE_CNT_MAX, 200, consecutive high samples required to assert the output. Must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- glitchy_signal  input  WIDTH  synchronized, undebounced inputs.
- debounced_signal  output  WIDTH  debounced level per bit.

Interface: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Sample counter:
  - Shared by all bits; width $clog2(SAMPLE_CNT_MAX).
  - Counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick is combinational and high when count == SAMPLE_CNT_MAX-1. It is therefore high for one cycle every SAMPLE_CNT_MAX cycles.
- Per-bit saturating counter:
  - Width $clog2(PULSE_CNT_MAX+1).
  - Updated at each clk edge, first matching rule wins:
    1. Input bit low: counter <= 0. This applies every cycle, independent of sample_tick.
    2. sample_tick high and counter < PULSE_CNT_MAX: counter <= counter+1.
    3. Otherwise: hold. Saturation at PULSE_CNT_MAX never wraps.
- Output:
  - debounced_signal[i] = (counter[i] == PULSE_CNT_MAX). Decoded from a register only; no path from glitchy_signal.
- Latency:
  - Rise: the output goes high at the edge where the PULSE_CNT_MAX-th consecutive tick is taken while the input is held high.
  - Fall: the output goes low at the first edge at which the input is low.
- Simultaneous events: input low on a tick cycle means clear wins.
- Bit independence: bits are fully independent except for the shared sample_tick.
- Reset:
  - rst asserted at any time, including mid-count, clears the sample counter and all per-bit counters immediately.
  - debounced_signal = 0 while rst is high.
  - Counting restarts from 0 on the first edge after release.
- Assertions (simulation): reject SAMPLE_CNT_MAX < 2 and PULSE_CNT_MAX < 1.

Optional Feature:
- Macro: DEBOUNCER_EDGE_EN.
- When defined:
  - Adds output port debounced_rise (output, WIDTH).
  - A bit pulses high for exactly one cycle, on the cycle after debounced_signal rises.
  - Implemented with one registered copy of debounced_signal and (cur & ~prev).
  - Reset value 0.
  - Holding the input high produces no further pulses.
- When undefined:
  - Port and register are absent.
  - debounced_signal behaviour is identical in both builds.

Decomposition:
- Package io_pkg:
  - Width helper constants for counter sizing.
  - Default SAMPLE_CNT_MAX and PULSE_CNT_MAX localparams shared with the top-level board wrapper.
- Sub-module debounce_channel:
  - One bit's saturating counter and compare.
  - Instantiated WIDTH times in a generate loop; takes sample_tick as an input.
  - The shared sample counter stays in debouncer.

Test Plan (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2):
- Hold high from reset: rst released, glitchy_signal=2'b01 held from edge 1 -> debounced_signal[0] rises after edge 12 and stays high; bit 1 stays 0.
- Glitch rejection: bit 0 high for edges 1-9, low for edge 10, high again -> output never rises before edge 10. The count restarts and the output rises after edge 20.
- Release: after bit 0 is debounced high, drive it low -> debounced_signal[0]=0 after the next edge.
- Simultaneous clear and tick: drive the input low exactly on a sample_tick cycle -> the counter becomes 0, not incremented.
- Reset mid-count: assert rst when bit 0 has counted 2 ticks -> the output stays 0. After release, a full 3 ticks (edge 12 relative to release) are required.
- DEBOUNCER_EDGE_EN build: the hold-high scenario gives exactly one debounced_rise[0] pulse, high after edge 13. No further pulses over 100 cycles of continued high input.

Source files
------------

// File: rtl/io_pkg.sv
// Shared sizing helpers and board-level defaults for the io_circuits debouncer.
package io_pkg;

  localparam int DEFAULT_SAMPLE_CNT_MAX = 62500;
  localparam int DEFAULT_PULSE_CNT_MAX  = 200;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_SAMPLE_CNT_W = cnt_width(DEFAULT_SAMPLE_CNT_MAX);
  localparam int DEFAULT_PULSE_CNT_W  = cnt_width(DEFAULT_PULSE_CNT_MAX + 1);

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: saturating count of consecutive high sample ticks.
module debounce_channel
  import io_pkg::*;
#(
  parameter int PULSE_CNT_MAX = DEFAULT_PULSE_CNT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic glitchy,
  output logic debounced
);

  localparam int PW = cnt_width(PULSE_CNT_MAX + 1);
  localparam logic [PW-1:0] PULSE_TOP = PW'(PULSE_CNT_MAX);

  logic [PW-1:0] count;

  // A low sample clears every cycle, even on a tick; saturates at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!glitchy) begin
      count <= '0;
    end else if (sample_tick && (count < PULSE_TOP)) begin
      count <= count + 1'b1;
    end
  end

  assign debounced = (count == PULSE_TOP);

endmodule

// File: rtl/debouncer.sv
// Per-bit debouncer for already-synchronized inputs with a shared sample tick.
// Optional macro DEBOUNCER_EDGE_EN adds a one-cycle debounced_rise pulse output.
module debouncer
  import io_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal
`ifdef DEBOUNCER_EDGE_EN
  ,
  output logic [WIDTH-1:0] debounced_rise
`endif
);

  localparam int SW = cnt_width(SAMPLE_CNT_MAX);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);

  logic [SW-1:0] sample_count;
  logic          sample_tick;

  always @(posedge clk) begin
    assert (SAMPLE_CNT_MAX >= 2) else $error("debouncer: SAMPLE_CNT_MAX must be >= 2");
    assert (PULSE_CNT_MAX >= 1) else $error("debouncer: PULSE_CNT_MAX must be >= 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
    end else if (sample_count == SAMPLE_LAST) begin
      sample_count <= '0;
    end else begin
      sample_count <= sample_count + 1'b1;
    end
  end

  assign sample_tick = (sample_count == SAMPLE_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .PULSE_CNT_MAX(PULSE_CNT_MAX)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(sample_tick),
      .glitchy    (glitchy_signal[i]),
      .debounced  (debounced_signal[i])
    );
  end

`ifdef DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] prev_debounced;

  // The pulse is registered, so it lands one cycle after the level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_debounced <= '0;
      debounced_rise <= '0;
    end else begin
      prev_debounced <= debounced_signal;
      debounced_rise <= debounced_signal & ~prev_debounced;
    end
  end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Table-driven bench for debouncer with SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2.
module tb_debouncer;

  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] glitchy_signal = '0;
  logic [WIDTH-1:0] debounced_signal;
`ifdef DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] debounced_rise;
`endif

  debouncer #(
    .WIDTH         (WIDTH),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .glitchy_signal  (glitchy_signal),
    .debounced_signal(debounced_signal)
`ifdef DEBOUNCER_EDGE_EN
    ,
    .debounced_rise  (debounced_rise)
`endif
  );

  always #5 clk = ~clk;

  // A reset record asserts rst for one edge; others apply din for one edge.
  typedef struct {
    bit               do_rst;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dexp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] exp_last = '0;
  logic [WIDTH-1:0] exp_prev = '0;
  logic [WIDTH-1:0] rise_exp = '0;

  function automatic void addVec(bit r, logic [WIDTH-1:0] din, logic [WIDTH-1:0] dexp, int n);
    vec_t v;
    v.do_rst = r;
    v.din    = din;
    v.dexp   = dexp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp);
    checks++;
    if (debounced_signal !== exp) begin
      errors++;
      $display("[TB] FAIL %s debounced_signal got %b expected %b", name, debounced_signal, exp);
    end
`ifdef DEBOUNCER_EDGE_EN
    checks++;
    if (debounced_rise !== rise_exp) begin
      errors++;
      $display("[TB] FAIL %s debounced_rise got %b expected %b", name, debounced_rise, rise_exp);
    end
`endif
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.do_rst) begin
      rst = 1'b1;
      glitchy_signal = v.din;
      exp_last = '0;
      exp_prev = '0;
      rise_exp = '0;
      #1;
      checkOutput($sformatf("vec%0d_async_rst", idx), '0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_in_rst", idx), v.dexp);
      rst = 1'b0;
    end else begin
      glitchy_signal = v.din;
      @(posedge clk);
      #1;
      rise_exp = exp_last & ~exp_prev;
      exp_prev = exp_last;
      exp_last = v.dexp;
      checkOutput($sformatf("vec%0d", idx), v.dexp);
    end
  endtask

  initial begin
    // Hold bit 0 high from reset: ticks land on edges 4, 8, 12.
    addVec(1, 2'b01, 2'b00, 1);
    addVec(0, 2'b01, 2'b00, 11);
    addVec(0, 2'b01, 2'b01, 103);
    addVec(0, 2'b00, 2'b00, 2);

    // Glitch on bit 0 at edge 10 restarts its count; bit 1 unaffected.
    addVec(1, 2'b11, 2'b00, 1);
    addVec(0, 2'b11, 2'b00, 9);
    addVec(0, 2'b10, 2'b00, 1);
    addVec(0, 2'b11, 2'b00, 1);
    addVec(0, 2'b11, 2'b10, 8);
    addVec(0, 2'b11, 2'b11, 2);
    addVec(0, 2'b01, 2'b01, 1);

    // Input low exactly on the tick at edge 8: clear must win.
    addVec(1, 2'b01, 2'b00, 1);
    addVec(0, 2'b01, 2'b00, 7);
    addVec(0, 2'b00, 2'b00, 1);
    addVec(0, 2'b01, 2'b00, 11);
    addVec(0, 2'b01, 2'b01, 1);

    // Reset after two ticks: a full three ticks are needed again.
    addVec(1, 2'b01, 2'b00, 1);
    addVec(0, 2'b01, 2'b00, 9);
    addVec(1, 2'b01, 2'b00, 1);
    addVec(0, 2'b01, 2'b00, 11);
    addVec(0, 2'b01, 2'b01, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
